audio_out_mixer: RTL and testbench

AUDIO_OUT_MIXER -- requirements
Module: audio_out_mixer

---
 rtl/audio_out_mixer.sv | 158 +++++++++++++++
 tb/tb_audio_out_mixer.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_out_mixer.sv
// Audio output mixer: sums synth voices, test tone or codec loopback
// into a one-slot sample register pushed to the codec output FIFO.
module audio_out_mixer #(
    parameter int W      = 32,
    parameter int IN_W   = 16,
    parameter int NUM_V  = 4,
    parameter int SR_DIV = 1042
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [NUM_V*IN_W-1:0] voices_in,
    input  logic [NUM_V-1:0]      voice_en,
    input  logic [1:0]            mode,
    input  logic [2:0]            vol,
    input  logic [3:0]            tone_sel,
    input  logic                  audio_in_available,
    input  logic [W-1:0]          left_in,
    input  logic [W-1:0]          right_in,
    output logic                  read_audio_in,
    input  logic                  audio_out_allowed,
    output logic [W-1:0]          left_out,
    output logic [W-1:0]          right_out,
    output logic                  write_audio_out,
    output logic [15:0]           drop_cnt,
    output logic                  clip
);

    localparam int SUM_W = IN_W + $clog2(NUM_V);
    localparam int CW    = (SR_DIV > 1) ? $clog2(SR_DIV) : 1;

    localparam logic [CW-1:0]   TICK_LAST = CW'(SR_DIV - 1);
    localparam logic [W-1:0]    TONE_HI   = W'(1) << (W - 4);
    localparam logic [W-1:0]    TONE_LO   = -TONE_HI;
    localparam logic [IN_W-1:0] SAT_MAX   = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0] SAT_MIN   = {1'b1, {(IN_W-1){1'b0}}};

    logic [CW-1:0] tick_cnt;
    logic          tick;

    logic [18:0] tone_cnt;
    logic [18:0] tone_lim;
    logic        snd;

    logic [W-1:0] cap_l;
    logic [W-1:0] cap_r;
    logic [W-1:0] pend_l;
    logic [W-1:0] pend_r;
    logic         pend_valid;

    logic signed [SUM_W-1:0] mix_sum;
    logic signed [SUM_W-1:0] mix_shr;
    logic [SUM_W-IN_W:0]     mix_hi;
    logic                    mix_ovf;
    logic [IN_W-1:0]         mix_sat;
    logic [W-1:0]            mix_w;
    logic [W-1:0]            tone_w;

    logic [W-1:0] next_l;
    logic [W-1:0] next_r;
    logic         next_clip;

    assign tick     = (tick_cnt == TICK_LAST);
    assign tone_lim = {tone_sel, 15'd3000};

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < NUM_V; i++) begin
            if (voice_en[i]) begin
                mix_sum = mix_sum
                        + SUM_W'($signed(voices_in[i*IN_W +: IN_W]));
            end
        end
    end

    // Saturation: every bit above the IN_W sign bit must match it.
    assign mix_shr = mix_sum >>> vol;
    assign mix_hi  = mix_shr[SUM_W-1:IN_W-1];
    assign mix_ovf = !((&mix_hi) || !(|mix_hi));
    assign mix_sat = !mix_ovf ? mix_shr[IN_W-1:0]
                   : (mix_shr[SUM_W-1] ? SAT_MIN : SAT_MAX);
    assign mix_w   = W'(mix_sat) << (W - IN_W);

    assign tone_w = $signed(snd ? TONE_HI : TONE_LO) >>> vol;

    always_comb begin
        next_l    = '0;
        next_r    = '0;
        next_clip = 1'b0;
        unique case (mode)
            2'd0: begin
                next_l = '0;
                next_r = '0;
            end
            2'd1: begin
                next_l    = mix_w;
                next_r    = mix_w;
                next_clip = mix_ovf;
            end
            2'd2: begin
                next_l = tone_w;
                next_r = tone_w;
            end
            2'd3: begin
                next_l = cap_l;
                next_r = cap_r;
            end
        endcase
    end

    assign read_audio_in   = resetn & audio_in_available;
    assign write_audio_out = resetn & pend_valid & audio_out_allowed;
    assign left_out        = resetn ? pend_l : '0;
    assign right_out       = resetn ? pend_r : '0;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            tick_cnt   <= '0;
            tone_cnt   <= '0;
            snd        <= 1'b0;
            cap_l      <= '0;
            cap_r      <= '0;
            pend_l     <= '0;
            pend_r     <= '0;
            pend_valid <= 1'b0;
            drop_cnt   <= '0;
            clip       <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            if (tone_cnt == tone_lim) begin
                tone_cnt <= '0;
                snd      <= ~snd;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end

            if (read_audio_in) begin
                cap_l <= left_in;
                cap_r <= right_in;
            end

            // A tick always reloads the slot; an unsent sample is lost.
            if (tick) begin
                pend_l     <= next_l;
                pend_r     <= next_r;
                clip       <= next_clip;
                pend_valid <= 1'b1;
                if (pend_valid && !write_audio_out
                    && drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end else if (write_audio_out) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_out_mixer.sv
// Self-checking bench for audio_out_mixer with a behavioural
// sample-slot reference model.
module tb_audio_out_mixer;

    localparam int W      = 32;
    localparam int IN_W   = 16;
    localparam int NUM_V  = 4;
    localparam int SR_DIV = 1042;

    logic                  CLOCK_50 = 1'b0;
    logic                  resetn;
    logic [NUM_V*IN_W-1:0] voices_in;
    logic [NUM_V-1:0]      voice_en;
    logic [1:0]            mode;
    logic [2:0]            vol;
    logic [3:0]            tone_sel;
    logic                  audio_in_available;
    logic [W-1:0]          left_in;
    logic [W-1:0]          right_in;
    logic                  read_audio_in;
    logic                  audio_out_allowed;
    logic [W-1:0]          left_out;
    logic [W-1:0]          right_out;
    logic                  write_audio_out;
    logic [15:0]           drop_cnt;
    logic                  clip;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_out_mixer #(
        .W(W), .IN_W(IN_W), .NUM_V(NUM_V), .SR_DIV(SR_DIV)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .resetn(resetn),
        .voices_in(voices_in),
        .voice_en(voice_en),
        .mode(mode),
        .vol(vol),
        .tone_sel(tone_sel),
        .audio_in_available(audio_in_available),
        .left_in(left_in),
        .right_in(right_in),
        .read_audio_in(read_audio_in),
        .audio_out_allowed(audio_out_allowed),
        .left_out(left_out),
        .right_out(right_out),
        .write_audio_out(write_audio_out),
        .drop_cnt(drop_cnt),
        .clip(clip)
    );

    function automatic void ref_sample(
        input  logic [1:0]  md,
        input  logic [2:0]  vl,
        input  logic [63:0] vs,
        input  logic [3:0]  en,
        input  logic [31:0] cl,
        input  logic [31:0] cr,
        input  bit          sn,
        output logic [31:0] ol,
        output logic [31:0] orr,
        output bit          oc
    );
        int s;
        int t;
        ol  = 32'd0;
        orr = 32'd0;
        oc  = 1'b0;
        case (md)
            2'd1: begin
                s = 0;
                for (int i = 0; i < 4; i++)
                    if (en[i]) s += int'($signed(vs[i*16 +: 16]));
                s = s >>> vl;
                if (s > 32767) begin
                    s  = 32767;
                    oc = 1'b1;
                end else if (s < -32768) begin
                    s  = -32768;
                    oc = 1'b1;
                end
                ol  = 32'(s * 65536);
                orr = ol;
            end
            2'd2: begin
                t   = sn ? 268435456 : -268435456;
                t   = t >>> vl;
                ol  = 32'(t);
                orr = ol;
            end
            2'd3: begin
                ol  = cl;
                orr = cr;
            end
            default: ;
        endcase
    endfunction

    int          ecnt;
    logic        m_valid;
    logic [31:0] m_l, m_r, m_cap_l, m_cap_r;
    logic [15:0] m_drop;
    logic        m_clip;
    logic [31:0] t_l, t_r;
    bit          t_c;

    always @(posedge CLOCK_50) begin
        if (!resetn) begin
            ecnt    <= 0;
            m_valid <= 1'b0;
            m_l     <= '0;
            m_r     <= '0;
            m_cap_l <= '0;
            m_cap_r <= '0;
            m_drop  <= '0;
            m_clip  <= 1'b0;
        end else begin
            ecnt <= ecnt + 1;
            if (audio_in_available) begin
                m_cap_l <= left_in;
                m_cap_r <= right_in;
            end
            if (ecnt % SR_DIV == SR_DIV - 1) begin
                ref_sample(mode, vol, voices_in, voice_en, m_cap_l,
                           m_cap_r, ((ecnt / 3001) % 2) == 1,
                           t_l, t_r, t_c);
                m_l     <= t_l;
                m_r     <= t_r;
                m_clip  <= t_c;
                m_valid <= 1'b1;
                if (m_valid && !audio_out_allowed && m_drop != 16'hFFFF)
                    m_drop <= m_drop + 16'd1;
            end else if (m_valid && audio_out_allowed) begin
                m_valid <= 1'b0;
            end
        end
    end

    task automatic do_reset(input int n);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        repeat (n) @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    task automatic wait_write(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * SR_DIV + 4; i++) begin
            @(negedge CLOCK_50);
            if (write_audio_out === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 2 * SR_DIV + 4; i++) begin
            @(negedge CLOCK_50);
            if (ecnt > 0 && ecnt % SR_DIV == 0) break;
        end
    endtask

    task automatic test_reset();
        int c;
        int first;
        mode = 2'd1;
        voices_in = {$urandom, $urandom};
        voice_en = 4'hF;
        vol = 3'd0;
        audio_out_allowed = 1'b1;
        audio_in_available = 1'b1;
        left_in = $urandom;
        right_in = $urandom;
        @(negedge CLOCK_50);
        resetn = 1'b0;
        repeat (5) begin
            @(negedge CLOCK_50);
            total_cnt++;
            if ({left_out, right_out, write_audio_out, read_audio_in,
                 drop_cnt, clip} !== '0)
                $display("FAIL reset_outputs: l=%h r=%h wr=%b rd=%b dc=%h cl=%b want all 0",
                         left_out, right_out, write_audio_out,
                         read_audio_in, drop_cnt, clip);
            else pass_cnt++;
        end
        resetn = 1'b1;
        #1;
        total_cnt++;
        if (read_audio_in !== 1'b1)
            $display("FAIL reset_read_release: got %b want 1", read_audio_in);
        else pass_cnt++;
        c = 1;
        first = 0;
        while (first == 0 && c < 1100) begin
            @(negedge CLOCK_50);
            c++;
            if (write_audio_out === 1'b1) first = c;
        end
        total_cnt++;
        if (first !== 1043)
            $display("FAIL reset_first_write: got cycle %0d want 1043", first);
        else pass_cnt++;
        total_cnt++;
        if (left_out !== m_l || right_out !== m_r)
            $display("FAIL reset_first_data: got %h/%h want %h/%h",
                     left_out, right_out, m_l, m_r);
        else pass_cnt++;
        audio_in_available = 1'b0;
    endtask

    task automatic test_mix_saturation();
        bit ok;
        mode = 2'd1;
        voices_in = {4{16'h4000}};
        voice_en = 4'hF;
        vol = 3'd0;
        wait_write(ok);
        total_cnt++;
        if (!ok || left_out !== 32'h7FFF0000 || right_out !== 32'h7FFF0000)
            $display("FAIL sat_vol0: ok=%b got %h/%h want 7fff0000",
                     ok, left_out, right_out);
        else pass_cnt++;
        total_cnt++;
        if (clip !== 1'b1)
            $display("FAIL sat_vol0_clip: got %b want 1", clip);
        else pass_cnt++;
        vol = 3'd2;
        wait_write(ok);
        total_cnt++;
        if (!ok || left_out !== 32'h40000000 || right_out !== 32'h40000000)
            $display("FAIL sat_vol2: ok=%b got %h/%h want 40000000",
                     ok, left_out, right_out);
        else pass_cnt++;
        total_cnt++;
        if (clip !== 1'b0)
            $display("FAIL sat_vol2_clip: got %b want 0", clip);
        else pass_cnt++;
    endtask

    task automatic test_negative();
        bit ok;
        mode = 2'd1;
        voices_in = 64'h0000_0000_0000_FFFF;
        voice_en = 4'b0001;
        vol = 3'd1;
        wait_write(ok);
        total_cnt++;
        if (!ok || left_out !== 32'hFFFF0000 || right_out !== 32'hFFFF0000)
            $display("FAIL negative: ok=%b got %h/%h want ffff0000",
                     ok, left_out, right_out);
        else pass_cnt++;
    endtask

    task automatic test_random_mix();
        bit ok;
        for (int k = 0; k < 8; k++) begin
            mode = 2'($urandom_range(0, 3));
            voices_in = {$urandom, $urandom};
            voice_en = 4'($urandom);
            vol = 3'($urandom);
            wait_write(ok);
            total_cnt++;
            if (!ok || left_out !== m_l || right_out !== m_r
                || clip !== m_clip)
                $display("FAIL random_mix[%0d]: ok=%b got %h/%h c%b want %h/%h c%b",
                         k, ok, left_out, right_out, clip,
                         m_l, m_r, m_clip);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e3, er;
        bit ec;
        int nw;
        mode = 2'd1;
        vol = 3'($urandom_range(0, 3));
        voice_en = 4'hF;
        audio_out_allowed = 1'b0;
        voices_in = {$urandom, $urandom};
        do_reset(3);
        wait_tick();
        voices_in = {$urandom, $urandom};
        wait_tick();
        voices_in = {$urandom, $urandom};
        ref_sample(mode, vol, voices_in, voice_en, 32'd0, 32'd0, 1'b0,
                   e3, er, ec);
        wait_tick();
        total_cnt++;
        if (drop_cnt !== 16'd2)
            $display("FAIL bp_drop: got %0d want 2", drop_cnt);
        else pass_cnt++;
        total_cnt++;
        if (write_audio_out !== 1'b0 || left_out !== e3)
            $display("FAIL bp_hold: wr=%b l=%h want wr=0 l=%h",
                     write_audio_out, left_out, e3);
        else pass_cnt++;
        repeat ($urandom_range(50, 400)) @(negedge CLOCK_50);
        audio_out_allowed = 1'b1;
        #1;
        nw = 0;
        for (int i = 0; i < SR_DIV; i++) begin
            if (write_audio_out === 1'b1) begin
                nw++;
                total_cnt++;
                if (left_out !== e3 || right_out !== e3)
                    $display("FAIL bp_data: got %h/%h want %h",
                             left_out, right_out, e3);
                else pass_cnt++;
            end
            if (ecnt % SR_DIV == SR_DIV - 1) break;
            @(negedge CLOCK_50);
        end
        total_cnt++;
        if (nw !== 1)
            $display("FAIL bp_write_count: got %0d want 1", nw);
        else pass_cnt++;
        total_cnt++;
        if (drop_cnt !== m_drop)
            $display("FAIL bp_drop_model: got %0d want %0d", drop_cnt, m_drop);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea, eb, er;
        logic [63:0] va;
        bit ec;
        mode = 2'd1;
        vol = 3'd1;
        voice_en = 4'hF;
        audio_out_allowed = 1'b0;
        voices_in = {$urandom, $urandom};
        va = voices_in;
        ref_sample(mode, vol, va, voice_en, 32'd0, 32'd0, 1'b0, ea, er, ec);
        do_reset(2);
        wait_tick();
        for (int t = 0; t < 10; t++) begin
            voices_in = {$urandom, $urandom};
            ref_sample(mode, vol, voices_in, voice_en, 32'd0, 32'd0,
                       1'b0, eb, er, ec);
            if (eb != ea) break;
        end
        for (int i = 0; i < 2 * SR_DIV; i++) begin
            if (ecnt % SR_DIV == SR_DIV - 1) break;
            @(negedge CLOCK_50);
        end
        audio_out_allowed = 1'b1;
        #1;
        total_cnt++;
        if (write_audio_out !== 1'b1 || left_out !== ea)
            $display("FAIL b2b_old: wr=%b l=%h want wr=1 l=%h",
                     write_audio_out, left_out, ea);
        else pass_cnt++;
        @(negedge CLOCK_50);
        total_cnt++;
        if (write_audio_out !== 1'b1 || left_out !== eb
            || drop_cnt !== 16'd0)
            $display("FAIL b2b_new: wr=%b l=%h dc=%0d want wr=1 l=%h dc=0",
                     write_audio_out, left_out, drop_cnt, eb);
        else pass_cnt++;
        @(negedge CLOCK_50);
        total_cnt++;
        if (write_audio_out !== 1'b0)
            $display("FAIL b2b_clear: wr=%b want 0", write_audio_out);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int c;
        int nw;
        mode = 2'd1;
        vol = 3'd0;
        voice_en = 4'hF;
        voices_in = {4{16'h1000}};
        audio_out_allowed = 1'b0;
        wait_tick();
        total_cnt++;
        if (write_audio_out !== 1'b0 || left_out !== 32'h40000000)
            $display("FAIL mid_pending: wr=%b l=%h want wr=0 l=40000000",
                     write_audio_out, left_out);
        else pass_cnt++;
        resetn = 1'b0;
        audio_out_allowed = 1'b1;
        #1;
        total_cnt++;
        if (write_audio_out !== 1'b0 || left_out !== 32'd0)
            $display("FAIL mid_gate: wr=%b l=%h want 0", write_audio_out, left_out);
        else pass_cnt++;
        @(negedge CLOCK_50);
        resetn = 1'b1;
        c = 1;
        nw = 0;
        while (c < 1042) begin
            @(negedge CLOCK_50);
            c++;
            if (write_audio_out === 1'b1) nw++;
        end
        total_cnt++;
        if (nw !== 0)
            $display("FAIL mid_discard: got %0d writes want 0", nw);
        else pass_cnt++;
        @(negedge CLOCK_50);
        total_cnt++;
        if (write_audio_out !== 1'b1 || left_out !== 32'h40000000)
            $display("FAIL mid_first: wr=%b l=%h want wr=1 l=40000000",
                     write_audio_out, left_out);
        else pass_cnt++;
    endtask

    task automatic test_tone();
        bit ok;
        logic [31:0] seq [3];
        seq[0] = 32'hF0000000;
        seq[1] = 32'hF0000000;
        seq[2] = 32'h10000000;
        mode = 2'd2;
        tone_sel = 4'd0;
        audio_out_allowed = 1'b1;
        do_reset(3);
        for (int k = 0; k < 6; k++) begin
            vol = (k < 3) ? 3'd0 : 3'($urandom);
            wait_write(ok);
            total_cnt++;
            if (!ok || left_out !== m_l || right_out !== m_r || clip !== 1'b0)
                $display("FAIL tone[%0d]: ok=%b got %h/%h c%b want %h",
                         k, ok, left_out, right_out, clip, m_l);
            else pass_cnt++;
            if (k < 3) begin
                total_cnt++;
                if (left_out !== seq[k])
                    $display("FAIL tone_seq[%0d]: got %h want %h",
                             k, left_out, seq[k]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_loopback();
        bit ok;
        logic [31:0] rr;
        mode = 2'd3;
        vol = 3'($urandom);
        audio_out_allowed = 1'b1;
        wait_write(ok);
        rr = $urandom;
        audio_in_available = 1'b1;
        left_in = 32'h12345678;
        right_in = rr;
        #1;
        total_cnt++;
        if (read_audio_in !== 1'b1)
            $display("FAIL loop_read: got %b want 1", read_audio_in);
        else pass_cnt++;
        @(negedge CLOCK_50);
        audio_in_available = 1'b0;
        left_in = $urandom;
        right_in = $urandom;
        #1;
        total_cnt++;
        if (read_audio_in !== 1'b0)
            $display("FAIL loop_read_off: got %b want 0", read_audio_in);
        else pass_cnt++;
        wait_write(ok);
        total_cnt++;
        if (!ok || left_out !== 32'h12345678 || right_out !== rr
            || clip !== 1'b0)
            $display("FAIL loopback: ok=%b got %h/%h c%b want 12345678/%h",
                     ok, left_out, right_out, clip, rr);
        else pass_cnt++;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed",
                 pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        voices_in = '0;
        voice_en = '0;
        mode = 2'd0;
        vol = 3'd0;
        tone_sel = 4'd0;
        audio_in_available = 1'b0;
        left_in = '0;
        right_in = '0;
        audio_out_allowed = 1'b0;
        test_reset();
        test_mix_saturation();
        test_negative();
        test_random_mix();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_tone();
        test_loopback();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
